// File: rtl/alu_pkg.sv
// Shared types for the two-requester ALU scheduler: operand widths, op codes,
// scheduler states and the request bundle latched at issue time.
package alu_pkg;

    localparam int WIDTH = 10;
    localparam int SHW   = 4;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_SHL = 3'b100,
        OP_SHR = 3'b110
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [2:0]       op;
        logic [SHW-1:0]   shl;
        logic [SHW-1:0]   shr;
    } alu_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins; on contention the
// requester that was not served last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one combinational ALU between two requesters: round-robin accept,
// registered operand issue, registered result capture and a valid/ready response.
module alu_rr_scheduler #(
    parameter int WIDTH = 10,
    parameter int SHW   = 4,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic [SHW-1:0]   req0_shl,
    input  logic [SHW-1:0]   req0_shr,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    input  logic [SHW-1:0]   req1_shl,
    input  logic [SHW-1:0]   req1_shr,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_control,
    output logic [SHW-1:0]   bits_left,
    output logic [SHW-1:0]   bits_right,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic [CNTW-1:0]  op_count,
    output logic             busy
);
    import alu_pkg::*;

    sched_state_e state_reg;
    logic         last_gnt_reg;
    logic [1:0]   gnt;
    alu_req_t     req_sel;

    rr_arb2 u_arb (
        .req  (req_valid),
        .last (last_gnt_reg),
        .gnt  (gnt)
    );

    // The grant is only an accept while idle; otherwise requesters must wait.
    assign req_ready = (state_reg == IDLE) ? gnt : 2'b00;
    assign busy      = (state_reg != IDLE);

    always_comb begin
        req_sel = '{a: req0_a, b: req0_b, op: req0_op, shl: req0_shl, shr: req0_shr};
        if (gnt[1]) begin
            req_sel = '{a: req1_a, b: req1_b, op: req1_op, shl: req1_shl, shr: req1_shr};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            last_gnt_reg <= 1'b1;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_control  <= '0;
            bits_left    <= '0;
            bits_right   <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_result   <= '0;
            rsp_flags    <= '0;
            op_count     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|gnt) begin
                        alu_a       <= req_sel.a;
                        alu_b       <= req_sel.b;
                        alu_control <= req_sel.op;
                        bits_left   <= req_sel.shl;
                        bits_right  <= req_sel.shr;
                        rsp_id      <= gnt[1];
                        state_reg   <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_flags  <= alu_flags;
                    rsp_valid  <= 1'b1;
                    state_reg  <= RESP;
                end
                RESP: begin
                    // Fairness is updated only once the response actually leaves.
                    if (rsp_ready) begin
                        rsp_valid    <= 1'b0;
                        last_gnt_reg <= rsp_id;
                        op_count     <= op_count + CNTW'(1);
                        state_reg    <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
